// File: rtl/issueque_int.sv
`default_nettype none
// issueque_int: compacted, age-ordered integer issue queue with CDB snooping;
// presents the oldest operand-ready entry to the ALU. Rev 1.0
module issueque_int #(
  parameter int DEPTH  = 4,
  parameter int W_TAG  = 6,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [5:0]        dispatch_opcode,
  input  logic [15:0]       dispatch_imm,
  input  logic [W_TAG-1:0]  dispatch_rdtag,
  input  logic [W_TAG-1:0]  dispatch_rstag,
  input  logic [W_TAG-1:0]  dispatch_rttag,
  input  logic [W_DATA-1:0] dispatch_rsdata,
  input  logic [W_DATA-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  output logic              dispatch_ready,
  input  logic [W_TAG-1:0]  cdb_tag,
  input  logic              cdb_valid,
  input  logic [W_DATA-1:0] cdb_data,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic [5:0]        issue_opcode,
  output logic [15:0]       issue_imm,
  output logic [W_TAG-1:0]  issue_rdtag,
  output logic [W_DATA-1:0] issue_rsdata,
  output logic [W_DATA-1:0] issue_rtdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              valid;
    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [W_TAG-1:0]  rdtag;
    logic [W_TAG-1:0]  rstag;
    logic [W_TAG-1:0]  rttag;
    logic [W_DATA-1:0] rsdata;
    logic [W_DATA-1:0] rtdata;
    logic              rsvalid;
    logic              rtvalid;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_nxt [DEPTH];
  entry_t           incoming;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] src_idx;
  logic [IDX_W-1:0] wpos;
  logic             xfer;
  logic             wr;

  // Capture a broadcast only into operands still waiting on a matching tag.
  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [W_TAG-1:0] t,
                                   input logic [W_DATA-1:0] d);
    entry_t r;
    r = e;
    if (v && e.valid) begin
      if (!e.rsvalid && e.rstag == t) begin
        r.rsdata  = d;
        r.rsvalid = 1'b1;
      end
      if (!e.rtvalid && e.rttag == t) begin
        r.rtdata  = d;
        r.rtvalid = 1'b1;
      end
    end
    return r;
  endfunction

  // Oldest ready entry wins: scan high to low so the lowest index is kept.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].rsvalid && q[i].rtvalid) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = (count < CNT_W'(DEPTH));
  assign xfer           = sel_found & issue_ready;
  assign wr             = dispatch_en & dispatch_ready;
  assign wpos           = IDX_W'(count - CNT_W'(xfer));
  assign count_nxt      = count + CNT_W'(wr) - CNT_W'(xfer);

  assign incoming.valid   = 1'b1;
  assign incoming.opcode  = dispatch_opcode;
  assign incoming.imm     = dispatch_imm;
  assign incoming.rdtag   = dispatch_rdtag;
  assign incoming.rstag   = dispatch_rstag;
  assign incoming.rttag   = dispatch_rttag;
  assign incoming.rsdata  = dispatch_rsdata;
  assign incoming.rtdata  = dispatch_rtdata;
  assign incoming.rsvalid = dispatch_rsvalid;
  assign incoming.rtvalid = dispatch_rtvalid;

  // Compact over the issued slot, snoop at post-shift positions, then append.
  always_comb begin
    src_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src_idx = IDX_W'(i);
      if (xfer && IDX_W'(i) >= sel_idx && i < DEPTH - 1) begin
        src_idx = IDX_W'(i + 1);
      end
      q_nxt[i] = q[src_idx];
      if (xfer && i == DEPTH - 1) begin
        q_nxt[i].valid = 1'b0;
      end
      q_nxt[i] = snoop(q_nxt[i], cdb_valid, cdb_tag, cdb_data);
    end
    if (wr) begin
      q_nxt[wpos] = snoop(incoming, cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
    end
  end

  assign issue_valid  = sel_found;
  assign issue_opcode = sel_found ? q[sel_idx].opcode : '0;
  assign issue_imm    = sel_found ? q[sel_idx].imm    : '0;
  assign issue_rdtag  = sel_found ? q[sel_idx].rdtag  : '0;
  assign issue_rsdata = sel_found ? q[sel_idx].rsdata : '0;
  assign issue_rtdata = sel_found ? q[sel_idx].rtdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_issueque_int.sv
`default_nettype none
// tb_issueque_int: directed scenarios plus randomized traffic against a
// queue-based reference model of the integer issue queue.
module tb_issueque_int;

  localparam int DEPTH  = 4;
  localparam int W_TAG  = 6;
  localparam int W_DATA = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              dispatch_en;
  logic [5:0]        dispatch_opcode;
  logic [15:0]       dispatch_imm;
  logic [W_TAG-1:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
  logic [W_DATA-1:0] dispatch_rsdata, dispatch_rtdata;
  logic              dispatch_rsvalid, dispatch_rtvalid;
  logic              dispatch_ready;
  logic [W_TAG-1:0]  cdb_tag;
  logic              cdb_valid;
  logic [W_DATA-1:0] cdb_data;
  logic              issue_ready;
  logic              issue_valid;
  logic [5:0]        issue_opcode;
  logic [15:0]       issue_imm;
  logic [W_TAG-1:0]  issue_rdtag;
  logic [W_DATA-1:0] issue_rsdata, issue_rtdata;

  int tests_run = 0;
  int tests_failed = 0;

  issueque_int #(.DEPTH(DEPTH), .W_TAG(W_TAG), .W_DATA(W_DATA)) dut (
    .clk(clk), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
    .dispatch_imm(dispatch_imm), .dispatch_rdtag(dispatch_rdtag),
    .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_ready(dispatch_ready),
    .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_opcode(issue_opcode), .issue_imm(issue_imm),
    .issue_rdtag(issue_rdtag), .issue_rsdata(issue_rsdata),
    .issue_rtdata(issue_rtdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [W_TAG-1:0]  rdtag, rstag, rttag;
    logic [W_DATA-1:0] rsdata, rtdata;
    logic              rsv, rtv;
  } m_entry_t;

  m_entry_t mq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_en = 0; dispatch_opcode = '0; dispatch_imm = '0;
    dispatch_rdtag = '0; dispatch_rstag = '0; dispatch_rttag = '0;
    dispatch_rsdata = '0; dispatch_rtdata = '0;
    dispatch_rsvalid = 0; dispatch_rtvalid = 0;
    cdb_tag = '0; cdb_valid = 0; cdb_data = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [W_TAG-1:0] rd,
                      input logic [W_TAG-1:0] rst, input logic [W_DATA-1:0] rsd,
                      input logic rsv, input logic [W_DATA-1:0] rtd);
    dispatch_en = 1; dispatch_opcode = op; dispatch_imm = 16'h0010;
    dispatch_rdtag = rd; dispatch_rstag = rst; dispatch_rttag = '0;
    dispatch_rsdata = rsd; dispatch_rtdata = rtd;
    dispatch_rsvalid = rsv; dispatch_rtvalid = 1;
  endtask

  task automatic do_reset();
    idle(); issue_ready = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({dispatch_ready, issue_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_flags: ready/valid=%b expected 10", {dispatch_ready, issue_valid});
    end
    tests_run++;
    if ({issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: op=%h imm=%h rd=%h rs=%h rt=%h expected all 0",
               issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata);
    end
  endtask

  task automatic test_single_add();
    do_reset();
    disp(6'h20, 6'd5, 6'd0, 32'd3, 1'b1, 32'd4);
    issue_ready = 1;
    tests_run++;
    if (issue_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_latency: issue_valid=%b expected 0 before write", issue_valid);
    end
    step();
    idle();
    tests_run++;
    if ({issue_valid, issue_opcode, issue_rdtag, issue_rsdata, issue_rtdata} !==
        {1'b1, 6'h20, 6'd5, 32'd3, 32'd4}) begin
      tests_failed++;
      $display("FAIL add_issue: v=%b op=%h rd=%0d rs=%0d rt=%0d expected 1 20 5 3 4",
               issue_valid, issue_opcode, issue_rdtag, issue_rsdata, issue_rtdata);
    end
    step();
    tests_run++;
    if ({issue_valid, dispatch_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL add_drain: valid/ready=%b expected 01", {issue_valid, dispatch_ready});
    end
  endtask

  task automatic test_full();
    logic [W_TAG-1:0] exp_tags[4];
    do_reset();
    for (int t = 1; t <= DEPTH; t++) begin
      disp(6'h21, W_TAG'(t), 6'd0, 32'(t), 1'b1, 32'd0);
      step();
    end
    tests_run++;
    if (dispatch_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready: dispatch_ready=%b expected 0", dispatch_ready);
    end
    disp(6'h22, 6'd7, 6'd0, 32'd7, 1'b1, 32'd0);
    step();
    idle();
    tests_run++;
    if ({dispatch_ready, issue_rdtag} !== {1'b0, 6'd1}) begin
      tests_failed++;
      $display("FAIL full_ignore: ready=%b rd=%0d expected 0 1", dispatch_ready, issue_rdtag);
    end
    issue_ready = 1;
    step();
    tests_run++;
    if (dispatch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_reopen: dispatch_ready=%b expected 1", dispatch_ready);
    end
    exp_tags = '{6'd2, 6'd3, 6'd4, 6'd0};
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({issue_valid, issue_rdtag} !== {(k < 3), exp_tags[k]}) begin
        tests_failed++;
        $display("FAIL full_order%0d: v=%b rd=%0d expected %b %0d",
                 k, issue_valid, issue_rdtag, (k < 3), exp_tags[k]);
      end
      step();
    end
    issue_ready = 0;
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    disp(6'h04, 6'd10, 6'd9, 32'd0, 1'b0, 32'd1);
    step();
    disp(6'h05, 6'd11, 6'd0, 32'd2, 1'b1, 32'd2);
    step();
    idle();
    tests_run++;
    if ({issue_valid, issue_rdtag} !== {1'b1, 6'd11}) begin
      tests_failed++;
      $display("FAIL wake_bypass: v=%b rd=%0d expected 1 11", issue_valid, issue_rdtag);
    end
    issue_ready = 1;
    step();
    tests_run++;
    if (issue_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_wait: issue_valid=%b expected 0", issue_valid);
    end
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
    tests_run++;
    if (issue_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_same_cycle: issue_valid=%b expected 0", issue_valid);
    end
    step();
    idle();
    tests_run++;
    if ({issue_valid, issue_rdtag, issue_rsdata} !== {1'b1, 6'd10, 32'hDEAD}) begin
      tests_failed++;
      $display("FAIL wake_issue: v=%b rd=%0d rs=%h expected 1 10 0000dead",
               issue_valid, issue_rdtag, issue_rsdata);
    end
    step();
    issue_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [W_TAG-1:0] exp_tags[4];
    do_reset();
    disp(6'h20, 6'd20, 6'd0, 32'd1, 1'b1, 32'd1);
    step();
    disp(6'h20, 6'd21, 6'd12, 32'd0, 1'b0, 32'd5);
    step();
    disp(6'h20, 6'd22, 6'd0, 32'd7, 1'b1, 32'd8);
    issue_ready = 1;
    cdb_valid = 1; cdb_tag = 6'd12; cdb_data = 32'h1234;
    step();
    idle();
    issue_ready = 0;
    tests_run++;
    if ({issue_valid, issue_rdtag, issue_rsdata, dispatch_ready} !==
        {1'b1, 6'd21, 32'h1234, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_shift: v=%b rd=%0d rs=%h rdy=%b expected 1 21 00001234 1",
               issue_valid, issue_rdtag, issue_rsdata, dispatch_ready);
    end
    disp(6'h20, 6'd23, 6'd0, 32'd0, 1'b1, 32'd0);
    step();
    disp(6'h20, 6'd24, 6'd0, 32'd0, 1'b1, 32'd0);
    tests_run++;
    if (dispatch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_count3: dispatch_ready=%b expected 1", dispatch_ready);
    end
    step();
    idle();
    tests_run++;
    if (dispatch_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count4: dispatch_ready=%b expected 0", dispatch_ready);
    end
    issue_ready = 1;
    exp_tags = '{6'd21, 6'd22, 6'd23, 6'd24};
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({issue_valid, issue_rdtag} !== {1'b1, exp_tags[k]}) begin
        tests_failed++;
        $display("FAIL b2b_order%0d: v=%b rd=%0d expected 1 %0d",
                 k, issue_valid, issue_rdtag, exp_tags[k]);
      end
      step();
    end
    issue_ready = 0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      disp(6'h2a, W_TAG'(30 + t), 6'd40, 32'd0, 1'b0, 32'd0);
      step();
    end
    disp(6'h2a, 6'd33, 6'd0, 32'd0, 1'b1, 32'd0);
    cdb_valid = 1; cdb_tag = 6'd40; cdb_data = 32'h5555;
    issue_ready = 1;
    reset = 1;
    step();
    reset = 0;
    idle();
    tests_run++;
    if ({dispatch_ready, issue_valid, issue_rdtag, issue_rsdata} !== {1'b1, 1'b0, 6'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL midreset: rdy=%b v=%b rd=%0d rs=%h expected 1 0 0 0",
               dispatch_ready, issue_valid, issue_rdtag, issue_rsdata);
    end
    step();
    tests_run++;
    if (issue_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_hold: issue_valid=%b expected 0", issue_valid);
    end
    issue_ready = 0;
  endtask

  task automatic test_random();
    int k;
    int sz;
    logic exp_v;
    logic [W_DATA*2+W_TAG+16+6+1:0] exp_vec, act_vec;
    m_entry_t e;
    do_reset();
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      k = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (k < 0 && mq[i].rsv && mq[i].rtv) k = i;
      end
      exp_v = (k >= 0);
      exp_vec = {(mq.size() < DEPTH), exp_v, 6'd0, 16'd0, {W_TAG{1'b0}}, {W_DATA{1'b0}}, {W_DATA{1'b0}}};
      if (exp_v)
        exp_vec = {(mq.size() < DEPTH), 1'b1, mq[k].opcode, mq[k].imm, mq[k].rdtag,
                   mq[k].rsdata, mq[k].rtdata};
      act_vec = {dispatch_ready, issue_valid, issue_opcode, issue_imm, issue_rdtag,
                 issue_rsdata, issue_rtdata};
      tests_run++;
      if (act_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL rand_cyc%0d: got %h expected %h", cyc, act_vec, exp_vec);
      end

      reset            = ($urandom_range(0, 99) == 0);
      dispatch_en      = ($urandom_range(0, 9) < 6);
      dispatch_opcode  = 6'($urandom);
      dispatch_imm     = 16'($urandom);
      dispatch_rdtag   = 6'($urandom);
      dispatch_rstag   = 6'($urandom_range(0, 7));
      dispatch_rttag   = 6'($urandom_range(0, 7));
      dispatch_rsdata  = $urandom;
      dispatch_rtdata  = $urandom;
      dispatch_rsvalid = $urandom_range(0, 1) == 1;
      dispatch_rtvalid = $urandom_range(0, 1) == 1;
      cdb_valid        = $urandom_range(0, 1) == 1;
      cdb_tag          = 6'($urandom_range(0, 7));
      cdb_data         = $urandom;
      issue_ready      = ($urandom_range(0, 9) < 6);

      sz = mq.size();
      if (reset) begin
        mq.delete();
      end else begin
        if (exp_v && issue_ready) mq.delete(k);
        if (cdb_valid) begin
          for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (!e.rsv && e.rstag == cdb_tag) begin e.rsdata = cdb_data; e.rsv = 1; end
            if (!e.rtv && e.rttag == cdb_tag) begin e.rtdata = cdb_data; e.rtv = 1; end
            mq[i] = e;
          end
        end
        if (dispatch_en && sz < DEPTH) begin
          e.opcode = dispatch_opcode; e.imm = dispatch_imm; e.rdtag = dispatch_rdtag;
          e.rstag = dispatch_rstag; e.rttag = dispatch_rttag;
          e.rsdata = dispatch_rsdata; e.rtdata = dispatch_rtdata;
          e.rsv = dispatch_rsvalid; e.rtv = dispatch_rtvalid;
          if (cdb_valid && !e.rsv && e.rstag == cdb_tag) begin e.rsdata = cdb_data; e.rsv = 1; end
          if (cdb_valid && !e.rtv && e.rttag == cdb_tag) begin e.rtdata = cdb_data; e.rtv = 1; end
          mq.push_back(e);
        end
      end
      step();
    end
    reset = 0;
    idle();
    issue_ready = 0;
  endtask

  initial begin
    reset = 1;
    issue_ready = 0;
    idle();
    test_reset();
    test_single_add();
    test_full();
    test_cdb_wakeup();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
